booth_mult_ctrl: RTL and testbench

Sequential signed (two's-complement) multiplier controller using radix-2 Booth recoding. It time-shares one add/subtract datapath across WIDTH iterations, choosing add (sel=0), subtract (sel=1) or no-op at each step and arithmetic-shifting the partial product. It is the next step after the standalone combinational adder-subtractor in the arithmetic lab chain. Start/busy/done handshake towards a testbench or top-level sequencer.

---
 rtl/arith_pkg.sv | 17 +
 rtl/booth_addsub_step.sv | 22 ++
 rtl/booth_mult_ctrl.sv | 121 ++++++++++++
 tb/tb_booth_mult_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-lab types: FSM states, default operand width, Booth op codes.
// Pure declarations; no logic, no latency.
// No flow control.
package arith_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 4;

    localparam logic [1:0] OP_NOP = 2'd0;
    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;

endpackage

// File: rtl/booth_addsub_step.sv
// One Booth step adder-subtractor: t = acc + m (sel=0), acc - m (sel=1), acc (en=0).
// Combinational, zero latency.
// No flow control; result valid whenever inputs are.
module booth_addsub_step #(
    parameter int W = 5
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] m,
    input  logic         sel,
    input  logic         en,
    output logic [W-1:0] t
);

    logic [W-1:0] m_inv;
    logic [W-1:0] sum;

    // Subtract as acc + ~m + 1, the lab adder-subtractor structure.
    assign m_inv = m ^ {W{sel}};
    assign sum   = acc + m_inv + W'(sel);
    assign t     = en ? sum : acc;

endmodule

// File: rtl/booth_mult_ctrl.sv
// Sequential signed radix-2 Booth multiplier controller, one step per clock.
// Latency: start accepted at E0, done pulses in the cycle after E(WIDTH).
// start is only sampled in IDLE; requests during RUN are dropped, not queued.
module booth_mult_ctrl
    import arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             step;
    logic             last;

    logic [WIDTH:0]   acc;
    logic [WIDTH:0]   m;
    logic [WIDTH-1:0] q;
    logic             q_m1;
    logic [CW-1:0]    cnt;

    logic [1:0]       op;
    logic [WIDTH:0]   t;
    logic [WIDTH:0]   acc_sh;
    logic [WIDTH-1:0] q_sh;

    always_comb begin
        case ({q[0], q_m1})
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NOP;
        endcase
    end

    booth_addsub_step #(
        .W (WIDTH + 1)
    ) u_step (
        .acc (acc),
        .m   (m),
        .sel (op == OP_SUB),
        .en  (op != OP_NOP),
        .t   (t)
    );

    // Arithmetic right shift of {t, q, q_m1}; q_m1 picks up the old q[0].
    assign acc_sh = {t[WIDTH], t[WIDTH:1]};
    assign q_sh   = {t[0], q[WIDTH-1:1]};
    assign last   = (cnt == CW'(WIDTH - 1));
    assign busy   = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            m       <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            cnt     <= '0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            if (load) begin
                acc  <= '0;
                m    <= {a[WIDTH-1], a};
                q    <= b;
                q_m1 <= 1'b0;
                cnt  <= '0;
            end else if (step) begin
                acc  <= acc_sh;
                q    <= q_sh;
                q_m1 <= q[0];
                cnt  <= cnt + CW'(1);
                if (last) begin
                    product <= {acc_sh[WIDTH-1:0], q_sh};
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_mult_ctrl.sv
// Directed and exhaustive checks of the 4-bit Booth multiplier controller.
module tb_booth_mult_ctrl;

    localparam int W = 4;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int n_cmp = 0;
    int n_err = 0;

    booth_mult_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; pulses start and waits (bounded) for done.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [2*W-1:0] exp_p);
        int k;
        int nbusy;
        a     = av;
        b     = bv;
        start = 1'b1;
        nbusy = 0;
        for (k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) break;
            if (busy) nbusy++;
        end
        check_eq({tag, "_lat"}, 32'(k), 32'd5);
        check_eq({tag, "_busy"}, 32'(nbusy), 32'd4);
        check_eq({tag, "_prod"}, 32'(product), 32'(exp_p));
        @(negedge clk);
        check_eq({tag, "_pulse"}, 32'(done), 32'd0);
        check_eq({tag, "_hold"}, 32'(product), 32'(exp_p));
    endtask

    initial begin
        int k1;
        int k2;
        int ndone;
        int prod;
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic [2*W-1:0] exp_p;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_prod", 32'(product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("p3x2",   4'd3,  4'd2,  8'h06);
        run_op("m3xm4",  4'hD,  4'hC,  8'h0C);
        run_op("p5xm1",  4'd5,  4'hF,  8'hFB);
        run_op("m8xm8",  4'h8,  4'h8,  8'h40);
        run_op("m8xp7",  4'h8,  4'd7,  8'hC8);
        run_op("0xm8",   4'd0,  4'h8,  8'h00);

        // Start held high: 6*6 then 2*(-6), with operand noise mid-RUN.
        a = 4'd6; b = 4'd6; start = 1'b1;
        k1 = 0; k2 = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 2) begin a = 4'hF; b = 4'h3; end
            if (done && k1 == 0) begin
                k1 = k;
                check_eq("b2b_prod1", 32'(product), 32'h24);
                a = 4'd2; b = 4'hA;
            end else if (done) begin
                k2 = k;
                check_eq("b2b_prod2", 32'(product), 32'hF4);
                break;
            end
            if (k1 != 0 && k == k1 + 2) begin
                start = 1'b0;
                a = 4'h7; b = 4'h7;
            end
        end
        start = 1'b0;
        check_eq("b2b_first", 32'(k1), 32'd5);
        check_eq("b2b_space", 32'(k2 - k1), 32'd5);
        @(negedge clk);

        // Start pulse and operand changes mid-RUN are ignored and not queued.
        a = 4'h8; b = 4'd7; start = 1'b1;
        ndone = 0; k1 = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            start = (k == 2);
            if (k == 2) begin a = 4'd1; b = 4'd1; end
            if (done) begin
                ndone++;
                if (k1 == 0) k1 = k;
            end
        end
        check_eq("ign_lat", 32'(k1), 32'd5);
        check_eq("ign_ndone", 32'(ndone), 32'd1);
        check_eq("ign_prod", 32'(product), 32'hC8);

        // Asynchronous reset two edges into RUN.
        a = 4'd3; b = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_done", 32'(done), 32'd0);
        check_eq("arst_prod", 32'(product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check_eq("arst_nodone", 32'(ndone), 32'd0);
        run_op("post_rst", 4'hD, 4'hC, 8'h0C);

        // Exhaustive sweep against a signed-multiply model.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                av    = W'(i);
                bv    = W'(j);
                prod  = int'($signed(av)) * int'($signed(bv));
                exp_p = prod[2*W-1:0];
                run_op("sweep", av, bv, exp_p);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
